hline_setup: RTL and testbench

- Hardware line-setup stage that sits directly upstream of the horizontal-line z-buffer FSM.
- Accepts raw span endpoints (x1, x2, y, z1, z2) plus buffer base addresses.
- Computes the per-line parameters that stage consumes: pixel count, z slope (quotient), remainder, initial error, start z, framebuffer and z-buffer addresses.
- Pulses start only when the downstream stage is idle, and holds all outputs stable for the whole downstream line.

---
 rtl/hline_setup_if.sv | 32 +++
 rtl/hline_setup.sv | 227 ++++++++++++++++++++++
 tb/tb_hline_setup.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hline_setup_if.sv
// rtl/hline_setup_if.sv - request, downstream handshake and line-parameter bundle for hline_setup
interface hline_setup_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x1;
    logic [15:0] x2;
    logic [15:0] y;
    logic [31:0] z1;
    logic [31:0] z2;
    logic [31:0] fb_base;
    logic [31:0] zb_base;
    logic        ds_idle;
    logic        start;
    logic [31:0] dx;
    logic [31:0] slope;
    logic [31:0] rem;
    logic [31:0] err;
    logic [31:0] z_start;
    logic [31:0] fb_addr;
    logic [31:0] zbuff_addr;
    logic        busy;

    modport master (
        output in_valid, x1, x2, y, z1, z2, fb_base, zb_base, ds_idle,
        input  in_ready, start, dx, slope, rem, err, z_start, fb_addr, zbuff_addr, busy
    );

    modport slave (
        input  in_valid, x1, x2, y, z1, z2, fb_base, zb_base, ds_idle,
        output in_ready, start, dx, slope, rem, err, z_start, fb_addr, zbuff_addr, busy
    );
endinterface

// File: rtl/hline_setup.sv
// rtl/hline_setup.sv - horizontal-line setup: endpoint sort, z slope division, address generation
module hline_setup #(
    parameter int ZW          = 24,
    parameter int LOG2_STRIDE = 10
) (
    input  logic         clk,
    input  logic         nreset,
    hline_setup_if.slave bus
);
    localparam int CW = $clog2(ZW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_FIX,
        S_FIRE,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [15:0]   x1_q, x1_d, x2_q, x2_d, y_q, y_d;
    logic [ZW-1:0] z1_q, z1_d, z2_q, z2_d;
    logic [31:0]   fb_base_q, fb_base_d, zb_base_q, zb_base_d;

    logic [15:0]   span_q, span_d;
    logic [ZW-1:0] zs_q, zs_d;
    logic          neg_q, neg_d;
    logic [31:0]   fb_pend_q, fb_pend_d, zb_pend_q, zb_pend_d;

    logic [ZW-1:0] dvd_q, dvd_d;
    logic [15:0]   racc_q, racc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          drain_first_q, drain_first_d;

    logic [31:0]   dx_q, dx_d, slope_q, slope_d, rem_q, rem_d, err_q, err_d;
    logic [31:0]   zst_q, zst_d, fb_addr_q, fb_addr_d, zb_addr_q, zb_addr_d;

    logic          swap;
    logic [15:0]   xmin, xmax;
    logic [ZW-1:0] za_sel, zb_sel;
    logic [ZW:0]   dz, dz_abs;
    logic [31:0]   pix_off;
    logic [16:0]   trial, diff;
    logic          fits;
    logic [31:0]   q_ext;
    logic          span_zero;
    logic          unused_bits;

    // Endpoint ordering, depth delta and address offset from the latched request
    always_comb begin
        swap    = x2_q < x1_q;
        xmin    = swap ? x2_q : x1_q;
        xmax    = swap ? x1_q : x2_q;
        za_sel  = swap ? z2_q : z1_q;
        zb_sel  = swap ? z1_q : z2_q;
        dz      = {1'b0, zb_sel} - {1'b0, za_sel};
        dz_abs  = dz[ZW] ? (~dz + 1'b1) : dz;
        pix_off = ((32'(y_q) << LOG2_STRIDE) + 32'(xmin)) << 2;
    end

    // One restoring-division step; the quotient shifts into the dividend register
    always_comb begin
        trial     = {racc_q, dvd_q[ZW-1]};
        diff      = trial - {1'b0, span_q};
        fits      = trial >= {1'b0, span_q};
        q_ext     = 32'(dvd_q);
        span_zero = span_q == 16'd0;
    end

    assign unused_bits = ^{bus.z1[31:ZW], bus.z2[31:ZW], diff[16], dz_abs[ZW]};

    always_comb begin
        state_d       = state_q;
        x1_d          = x1_q;
        x2_d          = x2_q;
        y_d           = y_q;
        z1_d          = z1_q;
        z2_d          = z2_q;
        fb_base_d     = fb_base_q;
        zb_base_d     = zb_base_q;
        span_d        = span_q;
        zs_d          = zs_q;
        neg_d         = neg_q;
        fb_pend_d     = fb_pend_q;
        zb_pend_d     = zb_pend_q;
        dvd_d         = dvd_q;
        racc_d        = racc_q;
        cnt_d         = cnt_q;
        drain_first_d = drain_first_q;
        dx_d          = dx_q;
        slope_d       = slope_q;
        rem_d         = rem_q;
        err_d         = err_q;
        zst_d         = zst_q;
        fb_addr_d     = fb_addr_q;
        zb_addr_d     = zb_addr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    x1_d      = bus.x1;
                    x2_d      = bus.x2;
                    y_d       = bus.y;
                    z1_d      = bus.z1[ZW-1:0];
                    z2_d      = bus.z2[ZW-1:0];
                    fb_base_d = bus.fb_base;
                    zb_base_d = bus.zb_base;
                    state_d   = S_PREP;
                end
            end
            S_PREP: begin
                span_d    = xmax - xmin;
                zs_d      = za_sel;
                neg_d     = dz[ZW];
                fb_pend_d = fb_base_q + pix_off;
                zb_pend_d = zb_base_q + pix_off;
                dvd_d     = dz_abs[ZW-1:0];
                racc_d    = 16'd0;
                cnt_d     = CW'(ZW);
                state_d   = S_DIV;
            end
            S_DIV: begin
                dvd_d  = {dvd_q[ZW-2:0], fits};
                racc_d = fits ? diff[15:0] : trial[15:0];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Zero-length span: the divider result is meaningless, force q=r=0
                slope_d   = span_zero ? 32'd0 : (neg_q ? (32'd0 - q_ext) : q_ext);
                rem_d     = span_zero ? 32'd0 : 32'(racc_q);
                err_d     = 32'(span_q >> 1);
                dx_d      = 32'(span_q) + 32'd1;
                zst_d     = 32'(zs_q);
                fb_addr_d = fb_pend_q;
                zb_addr_d = zb_pend_q;
                if (bus.ds_idle) begin
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                drain_first_d = 1'b1;
                state_d       = S_DRAIN;
            end
            S_DRAIN: begin
                // Downstream still reports idle in the cycle right after start
                if (drain_first_q) begin
                    drain_first_d = 1'b0;
                end else if (bus.ds_idle) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q       <= S_IDLE;
            x1_q          <= '0;
            x2_q          <= '0;
            y_q           <= '0;
            z1_q          <= '0;
            z2_q          <= '0;
            fb_base_q     <= '0;
            zb_base_q     <= '0;
            span_q        <= '0;
            zs_q          <= '0;
            neg_q         <= 1'b0;
            fb_pend_q     <= '0;
            zb_pend_q     <= '0;
            dvd_q         <= '0;
            racc_q        <= '0;
            cnt_q         <= '0;
            drain_first_q <= 1'b0;
            dx_q          <= '0;
            slope_q       <= '0;
            rem_q         <= '0;
            err_q         <= '0;
            zst_q         <= '0;
            fb_addr_q     <= '0;
            zb_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            x1_q          <= x1_d;
            x2_q          <= x2_d;
            y_q           <= y_d;
            z1_q          <= z1_d;
            z2_q          <= z2_d;
            fb_base_q     <= fb_base_d;
            zb_base_q     <= zb_base_d;
            span_q        <= span_d;
            zs_q          <= zs_d;
            neg_q         <= neg_d;
            fb_pend_q     <= fb_pend_d;
            zb_pend_q     <= zb_pend_d;
            dvd_q         <= dvd_d;
            racc_q        <= racc_d;
            cnt_q         <= cnt_d;
            drain_first_q <= drain_first_d;
            dx_q          <= dx_d;
            slope_q       <= slope_d;
            rem_q         <= rem_d;
            err_q         <= err_d;
            zst_q         <= zst_d;
            fb_addr_q     <= fb_addr_d;
            zb_addr_q     <= zb_addr_d;
        end
    end

    assign bus.in_ready   = state_q == S_IDLE;
    assign bus.busy       = state_q != S_IDLE;
    assign bus.start      = state_q == S_FIRE;
    assign bus.dx         = dx_q;
    assign bus.slope      = slope_q;
    assign bus.rem        = rem_q;
    assign bus.err        = err_q;
    assign bus.z_start    = zst_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.zbuff_addr = zb_addr_q;
endmodule

// File: tb/tb_hline_setup.sv
// tb/tb_hline_setup.sv - scoreboard bench for hline_setup with directed line vectors
module tb_hline_setup;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    hline_setup_if bus();

    hline_setup #(.ZW(24), .LOG2_STRIDE(10)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] dx, slope, rem, err, zs, fb, zb;
        int          exp_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic         prev_start = 1'b0;
    int           fire_cyc = -1;
    logic [223:0] snap;
    logic         changed;

    always @(negedge clk) begin
        if (nreset && bus.start) begin
            check32("start_not_double", 32'(prev_start), 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_start: got start=1 expected no start (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check32("dx", bus.dx, mon_e.dx);
                check32("slope", bus.slope, mon_e.slope);
                check32("rem", bus.rem, mon_e.rem);
                check32("err", bus.err, mon_e.err);
                check32("z_start", bus.z_start, mon_e.zs);
                check32("fb_addr", bus.fb_addr, mon_e.fb);
                check32("zbuff_addr", bus.zbuff_addr, mon_e.zb);
                if (mon_e.exp_cyc >= 0) check32("start_cycle", 32'(cyc), 32'(mon_e.exp_cyc));
            end
            fire_cyc = cyc;
            changed  = 1'b0;
            snap     = {bus.dx, bus.slope, bus.rem, bus.err, bus.z_start, bus.fb_addr, bus.zbuff_addr};
        end else if (fire_cyc >= 0) begin
            if ({bus.dx, bus.slope, bus.rem, bus.err, bus.z_start, bus.fb_addr, bus.zbuff_addr} != snap)
                changed = 1'b1;
            if (!bus.busy) begin
                check32("drain_len", 32'(cyc - fire_cyc), 32'd3);
                check32("hold_stable", 32'(changed), 32'd0);
                fire_cyc = -1;
            end
        end
        prev_start = bus.start;
    end

    task automatic issue(input logic [15:0] x1, input logic [15:0] x2, input logic [15:0] y,
                         input logic [31:0] z1, input logic [31:0] z2,
                         input logic [31:0] fbb, input logic [31:0] zbb, input logic push,
                         input logic [31:0] edx, input logic [31:0] eslope, input logic [31:0] erem,
                         input logic [31:0] eerr, input logic [31:0] ezs, input logic [31:0] efb,
                         input logic [31:0] ezb, input int lat);
        exp_t e;
        int   n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1");
        end
        bus.x1 = x1; bus.x2 = x2; bus.y = y; bus.z1 = z1; bus.z2 = z2;
        bus.fb_base = fbb; bus.zb_base = zbb;
        bus.in_valid = 1'b1;
        if (push) begin
            e.dx = edx; e.slope = eslope; e.rem = erem; e.err = eerr;
            e.zs = ezs; e.fb = efb; e.zb = ezb;
            e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 expected 0");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.x1 = '0; bus.x2 = '0; bus.y = '0; bus.z1 = '0; bus.z2 = '0;
        bus.fb_base = '0; bus.zb_base = '0; bus.ds_idle = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check32("rst_busy", 32'(bus.busy), 32'd0);
        check32("rst_start", 32'(bus.start), 32'd0);
        check32("rst_dx", bus.dx, 32'd0);
        check32("rst_slope", bus.slope, 32'd0);
        check32("rst_fb_addr", bus.fb_addr, 32'd0);
        nreset = 1'b1;
        @(posedge clk); #1;

        issue(16'd0, 16'd10, 16'd0, 32'd100, 32'd130, 32'h0, 32'h0, 1'b1,
              32'd11, 32'd3, 32'd0, 32'd5, 32'd100, 32'h0, 32'h0, 27);
        wait_idle();
        issue(16'd20, 16'd10, 16'd0, 32'd50, 32'd10, 32'h0, 32'h0, 1'b1,
              32'd11, 32'd4, 32'd0, 32'd5, 32'd10, 32'h28, 32'h28, 27);
        wait_idle();
        issue(16'd0, 16'd4, 16'd0, 32'd100, 32'd90, 32'h0, 32'h0, 1'b1,
              32'd5, 32'hFFFF_FFFE, 32'd2, 32'd2, 32'd100, 32'h0, 32'h0, 27);
        repeat (5) @(posedge clk);
        #1;
        check32("busy_in_ready", 32'(bus.in_ready), 32'd0);
        bus.x1 = 16'd3; bus.x2 = 16'd300; bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_idle();
        issue(16'd7, 16'd7, 16'd0, 32'd9, 32'd500, 32'h0, 32'h0, 1'b1,
              32'd1, 32'd0, 32'd0, 32'd0, 32'd9, 32'h1C, 32'h1C, 27);
        wait_idle();
        issue(16'd5, 16'd9, 16'd3, 32'd0, 32'h1000, 32'h1000_0000, 32'h2000_0000, 1'b1,
              32'd5, 32'd1024, 32'd0, 32'd2, 32'd0, 32'h1000_3014, 32'h2000_3014, 27);
        wait_idle();
        issue(16'd0, 16'd2, 16'd0, 32'hFF00_0010, 32'hAB00_0000, 32'h0, 32'h0, 1'b1,
              32'd3, 32'hFFFF_FFF8, 32'd0, 32'd1, 32'h10, 32'h0, 32'h0, 27);
        wait_idle();
        issue(16'd0, 16'hFFFF, 16'd0, 32'd0, 32'h00FF_FFFF, 32'h0, 32'h0, 1'b1,
              32'h1_0000, 32'd256, 32'd255, 32'h7FFF, 32'd0, 32'h0, 32'h0, 27);
        wait_idle();

        bus.ds_idle = 1'b0;
        issue(16'd100, 16'd103, 16'd1, 32'd0, 32'd10, 32'h0, 32'h0, 1'b1,
              32'd4, 32'd3, 32'd1, 32'd1, 32'd0, 32'h1190, 32'h1190, -1);
        repeat (76) @(posedge clk);
        #1;
        check32("held_pending", 32'(sb.size()), 32'd1);
        check32("held_busy", 32'(bus.busy), 32'd1);
        if (sb.size() > 0) sb[0].exp_cyc = cyc + 1;
        bus.ds_idle = 1'b1;
        wait_idle();

        issue(16'd1, 16'd5, 16'd0, 32'd0, 32'd100, 32'h0, 32'h0, 1'b0,
              32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0, 32'h0, -1);
        repeat (10) @(posedge clk);
        #1;
        nreset = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
        check32("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check32("mid_rst_busy", 32'(bus.busy), 32'd0);
        check32("mid_rst_dx", bus.dx, 32'd0);
        check32("mid_rst_slope", bus.slope, 32'd0);
        check32("mid_rst_z_start", bus.z_start, 32'd0);
        check32("mid_rst_zbuff_addr", bus.zbuff_addr, 32'd0);
        repeat (40) @(posedge clk);
        #1;

        issue(16'd0, 16'd10, 16'd0, 32'd100, 32'd130, 32'h0, 32'h0, 1'b1,
              32'd11, 32'd3, 32'd0, 32'd5, 32'd100, 32'h0, 32'h0, 27);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        check32("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
